// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 memory arbiter: FSM state encoding, fetch/data access widths,
// status codes seen by the pipeline, and the address bounds helper.
package y86_mem_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIf0,
      StIf1,
      StDm,
      StErr
   } arb_state_e;

   localparam logic [3:0] STAT_AOK = 4'd1;
   localparam logic [3:0] STAT_ADR = 4'd3;

   localparam int unsigned IF_BYTES = 10;
   localparam int unsigned DM_BYTES = 8;

   // True when [addr, addr+nbytes) does not fit in the backing memory. The 65-bit sum keeps the
   // carry, so an access that would wrap past 2^64 is also reported as out of range.
   function automatic logic out_of_range(input logic [63:0] addr, input int unsigned nbytes,
                                         input int unsigned mem_bytes);
      logic [64:0] last;
      last = {1'b0, addr} + 65'(nbytes);
      return last > 65'(mem_bytes);
   endfunction

endpackage

// File: rtl/y86_mem_arbiter_timeout.sv
// Acknowledge timeout counter for the memory arbiter.
//  clk, rst_n : clock, synchronous active-low reset
//  clr        : force count to zero
//  en         : one more cycle spent waiting for mem_ack
//  expired    : this waiting cycle is the TIMEOUT-th; the requester must give up
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbitrates one single-ported backing memory between the fetch stage (10-byte reads, done as two
// 8-byte beats) and the memory stage (8-byte reads/writes). Data requests win in IDLE; a fetch in
// progress is never preempted. Out-of-range accesses and ack timeouts give a tagged error pulse.
//  clk, rst_n                       : clock, synchronous active-low reset
//  if_req/if_addr                   : fetch request, held until if_valid|if_err
//  if_rdata/if_valid/if_err         : fetch result, one-cycle pulses
//  dm_req/dm_we/dm_addr/dm_wdata    : data request, held until dm_valid|dm_err
//  dm_rdata/dm_valid/dm_err         : data result, one-cycle pulses
//  mem_req/mem_we/mem_addr/mem_wdata: backing memory request, held until mem_ack
//  mem_rdata/mem_ack                : backing memory response
//  f_stall_req/m_stall_req          : stall requests toward pipeline control
module y86_mem_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic [79:0] if_rdata,
   output logic        if_valid,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_wdata,
   output logic [63:0] dm_rdata,
   output logic        dm_valid,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        f_stall_req,
   output logic        m_stall_req
);

   arb_state_e  state;
   logic [63:0] fetch_lo;   // first fetch beat, held until the second arrives
   logic        err_dm;     // error tag for StErr: 1 = data side, 0 = fetch side
   logic        tmr_en;
   logic        tmr_expired;

   // Counting only unacknowledged request cycles; any ack or idle cycle restarts the count, which
   // covers every state entry (IDLE exits with mem_req low, IF0->IF1 happens on an ack).
   assign tmr_en = mem_req && !mem_ack;

   mem_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!tmr_en),
      .en     (tmr_en),
      .expired(tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         fetch_lo  <= '0;
         err_dm    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         if_err    <= 1'b0;
         dm_rdata  <= '0;
         dm_valid  <= 1'b0;
         dm_err    <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         dm_valid <= 1'b0;
         dm_err   <= 1'b0;
         unique case (state)
            StIdle: begin
               if (dm_req) begin
                  err_dm <= 1'b1;
                  if (out_of_range(dm_addr, DM_BYTES, MEM_BYTES)) begin
                     state <= StErr;
                  end else begin
                     state     <= StDm;
                     mem_req   <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end
               end else if (if_req) begin
                  err_dm <= 1'b0;
                  if (out_of_range(if_addr, IF_BYTES, MEM_BYTES)) begin
                     state <= StErr;
                  end else begin
                     state    <= StIf0;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr;
                  end
               end
            end
            StIf0: begin
               if (mem_ack) begin
                  fetch_lo <= mem_rdata;
                  mem_addr <= mem_addr + 64'd8;
                  state    <= StIf1;
               end else if (tmr_expired) begin
                  mem_req <= 1'b0;
                  if_err  <= 1'b1;
                  state   <= StIdle;
               end
            end
            StIf1: begin
               if (mem_ack) begin
                  if_rdata <= {mem_rdata[15:0], fetch_lo};
                  if_valid <= 1'b1;
                  mem_req  <= 1'b0;
                  fetch_lo <= '0;
                  state    <= StIdle;
               end else if (tmr_expired) begin
                  mem_req  <= 1'b0;
                  if_err   <= 1'b1;
                  fetch_lo <= '0;
                  state    <= StIdle;
               end
            end
            StDm: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;
                  end
                  dm_valid <= 1'b1;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  state    <= StIdle;
               end else if (tmr_expired) begin
                  dm_err  <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= StIdle;
               end
            end
            StErr: begin
               if (err_dm) begin
                  dm_err <= 1'b1;
               end else begin
                  if_err <= 1'b1;
               end
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign f_stall_req = if_req && !if_valid;
   assign m_stall_req = dm_req && !dm_valid;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
module tb_y86_mem_arbiter;

   localparam int unsigned MEM_BYTES = 4096;
   localparam int unsigned TIMEOUT   = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [63:0] if_addr;
   logic [79:0] if_rdata;
   logic        if_valid;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic [63:0] dm_rdata;
   logic        dm_valid;
   logic        dm_err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;
   logic        f_stall_req;
   logic        m_stall_req;

   always #5 clk = ~clk;

   y86_mem_arbiter #(
      .MEM_BYTES(MEM_BYTES),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_valid   (if_valid),
      .if_err     (if_err),
      .dm_req     (dm_req),
      .dm_we      (dm_we),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_rdata   (dm_rdata),
      .dm_valid   (dm_valid),
      .dm_err     (dm_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .f_stall_req(f_stall_req),
      .m_stall_req(m_stall_req)
   );

   typedef struct {
      bit          err;
      bit          chk;
      logic [79:0] data;
   } exp_t;

   exp_t         if_q[$];
   exp_t         dm_q[$];
   byte unsigned ram[MEM_BYTES];      // contents seen by the DUT through the memory port
   byte unsigned ref_mem[MEM_BYTES];  // reference contents, updated when a write is issued
   int           errors = 0;
   int           checks = 0;
   int           ack_delay = 0;
   int           wait_cnt = 0;
   int           mem_req_cycles = 0;
   longint       cyc = 0;
   longint       if_cyc = 0;
   longint       dm_cyc = 0;
   bit           done = 1'b0;
   int           lat_a;
   int           lat_b;
   int           snap;

   function automatic byte unsigned init_byte(input int i);
      logic [63:0] pat;
      pat = 64'h1122_3344_5566_7788;
      if (i >= 32 && i < 40) return pat[(i-32)*8 +: 8];
      if (i == 40) return 8'hBB;
      if (i == 41) return 8'hAA;
      return 8'((i * 37 + 11) & 255);
   endfunction

   function automatic bit in_range(input logic [63:0] a, input int unsigned n);
      return a <= 64'(MEM_BYTES - n);
   endfunction

   function automatic logic [79:0] ref_read(input logic [63:0] a, input int n);
      logic [79:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = ref_mem[int'(a) + i];
      return v;
   endfunction

   task automatic check_vec(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issues one request, records its expected outcome, and holds the request until the response
   // pulse, dropping it in the pulse cycle. lat = posedges from request to the pulse.
   task automatic run_txn(input bit is_dm, input bit we, input logic [63:0] addr,
                          input logic [63:0] wd, input int d, output int lat);
      exp_t e;
      int   n;
      n      = is_dm ? 8 : 10;
      e.err  = !in_range(addr, n) || (d >= int'(TIMEOUT));
      e.chk  = !e.err && !(is_dm && we);
      e.data = e.chk ? ref_read(addr, n) : '0;
      if (!e.err && is_dm && we) begin
         for (int i = 0; i < 8; i++) ref_mem[int'(addr) + i] = wd[i*8 +: 8];
      end
      ack_delay = d;
      if (is_dm) begin
         dm_q.push_back(e);
         dm_we    = we;
         dm_addr  = addr;
         dm_wdata = wd;
         dm_req   = 1'b1;
      end else begin
         if_q.push_back(e);
         if_addr = addr;
         if_req  = 1'b1;
      end
      lat = 0;
      while (1) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         #1;
         if (is_dm ? (dm_valid || dm_err) : (if_valid || if_err)) break;
         if (lat >= 200) begin
            checks++;
            errors++;
            $display("FAIL txn_wait: no pulse after %0d cycles, expected a valid or err pulse", lat);
            break;
         end
      end
      if (is_dm) dm_req = 1'b0;
      else if_req = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      mem_ack  = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
         ram[i]     = init_byte(i);
         ref_mem[i] = init_byte(i);
      end
      fork
         // Stimulus
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1;
            check_bit("rst_mem_req", mem_req, 1'b0);
            check_bit("rst_if_valid", if_valid, 1'b0);
            check_bit("rst_if_err", if_err, 1'b0);
            check_bit("rst_dm_valid", dm_valid, 1'b0);
            check_bit("rst_dm_err", dm_err, 1'b0);
            check_vec("rst_if_rdata", if_rdata, 80'h0);
            check_vec("rst_dm_rdata", {16'h0, dm_rdata}, 80'h0);
            rst_n = 1'b1;
            @(negedge clk);
            #1;

            // Fetch at 0x20, ack every cycle
            run_txn(1'b0, 1'b0, 64'h20, 64'h0, 0, lat_a);
            check_vec("fetch_latency", 80'(lat_a), 80'd3);
            check_vec("fetch_data_direct", if_rdata, 80'hAABB_1122_3344_5566_7788);

            // Simultaneous write and fetch: data side first
            fork
               run_txn(1'b1, 1'b1, 64'h100, 64'hDEAD, 0, lat_a);
               run_txn(1'b0, 1'b0, 64'h20, 64'h0, 0, lat_b);
            join
            check_vec("both_dm_latency", 80'(lat_a), 80'd2);
            check_vec("both_if_latency", 80'(lat_b), 80'd5);
            check_bit("both_order", dm_cyc < if_cyc, 1'b1);
            run_txn(1'b1, 1'b0, 64'h100, 64'h0, 1, lat_a);

            // Out-of-range data read: error, no memory access
            snap = mem_req_cycles;
            run_txn(1'b1, 1'b0, 64'(MEM_BYTES - 4), 64'h0, 0, lat_a);
            check_vec("oor_latency", 80'(lat_a), 80'd2);
            check_vec("oor_no_mem_req", 80'(mem_req_cycles - snap), 80'd0);
            run_txn(1'b0, 1'b0, 64'(MEM_BYTES - 10), 64'h0, 0, lat_a);
            run_txn(1'b0, 1'b0, 64'(MEM_BYTES - 9), 64'h0, 0, lat_a);
            run_txn(1'b1, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 0, lat_a);
            run_txn(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 0, lat_a);

            // Ack withheld: timeout after TIMEOUT waiting cycles; one short of it still succeeds
            run_txn(1'b1, 1'b0, 64'h80, 64'h0, 1000, lat_a);
            check_vec("timeout_latency", 80'(lat_a), 80'(TIMEOUT + 1));
            check_bit("timeout_mem_req_drop", mem_req, 1'b0);
            run_txn(1'b1, 1'b0, 64'h88, 64'h0, int'(TIMEOUT) - 1, lat_a);
            run_txn(1'b0, 1'b0, 64'h40, 64'h0, int'(TIMEOUT), lat_a);

            // Reset during the second fetch beat
            ack_delay = 0;
            if_addr   = 64'h40;
            if_req    = 1'b1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            #1;
            rst_n  = 1'b0;
            if_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            #1;
            check_bit("rst_mid_mem_req", mem_req, 1'b0);
            check_bit("rst_mid_if_valid", if_valid, 1'b0);
            rst_n = 1'b1;
            repeat (3) begin
               @(negedge clk);
               #1;
            end
            run_txn(1'b0, 1'b0, 64'h40, 64'h0, 0, lat_a);
            check_vec("after_rst_fetch_latency", 80'(lat_a), 80'd3);

            // Data request while a fetch is in its first beat
            fork
               run_txn(1'b0, 1'b0, 64'h60, 64'h0, 0, lat_a);
               begin
                  @(negedge clk);
                  #1;
                  run_txn(1'b1, 1'b0, 64'h90, 64'h0, 0, lat_b);
               end
            join
            check_bit("if0_order", if_cyc < dm_cyc, 1'b1);

            // Randomized traffic
            for (int t = 0; t < 120; t++) begin
               int          kind;
               int          n;
               int          d;
               logic [63:0] addr;
               kind = $urandom_range(0, 2);
               n    = (kind == 0) ? 10 : 8;
               if ($urandom_range(0, 11) == 0) begin
                  case ($urandom_range(0, 3))
                     0:       addr = 64'(MEM_BYTES - n);
                     1:       addr = 64'(MEM_BYTES - n + 1);
                     2:       addr = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
                     default: addr = 64'(MEM_BYTES + $urandom_range(0, 100));
                  endcase
               end else begin
                  addr = 64'($urandom_range(0, 300));
               end
               d = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 3));
               run_txn(kind != 0, kind == 2, addr, {$urandom, $urandom}, d, lat_a);
               repeat ($urandom_range(0, 2)) begin
                  @(negedge clk);
                  #1;
               end
            end

            repeat (4) begin
               @(negedge clk);
               #1;
            end
            check_vec("if_queue_empty", 80'(if_q.size()), 80'd0);
            check_vec("dm_queue_empty", 80'(dm_q.size()), 80'd0);
            done = 1'b1;
         end

         // Monitor / scoreboard
         begin
            while (!done) begin
               exp_t e;
               @(negedge clk);
               cyc++;
               if (rst_n) begin
                  check_bit("f_stall_req", f_stall_req, if_req && !if_valid);
                  check_bit("m_stall_req", m_stall_req, dm_req && !dm_valid);
               end
               if (if_valid || if_err) begin
                  if_cyc = cyc;
                  if (if_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL if_unexpected: got valid=%b err=%b, expected no pulse",
                              if_valid, if_err);
                  end else begin
                     e = if_q.pop_front();
                     check_vec("if_pulse", {78'h0, if_valid, if_err}, {78'h0, !e.err, e.err});
                     if (e.chk) check_vec("if_rdata", if_rdata, e.data);
                  end
               end
               if (dm_valid || dm_err) begin
                  dm_cyc = cyc;
                  if (dm_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL dm_unexpected: got valid=%b err=%b, expected no pulse",
                              dm_valid, dm_err);
                  end else begin
                     e = dm_q.pop_front();
                     check_vec("dm_pulse", {78'h0, dm_valid, dm_err}, {78'h0, !e.err, e.err});
                     if (e.chk) check_vec("dm_rdata", {16'h0, dm_rdata}, e.data);
                  end
               end
            end
         end

         // Backing memory model with a per-transaction ack delay
         begin
            while (!done) begin
               @(negedge clk);
               if (mem_req === 1'b1) begin
                  mem_req_cycles++;
                  if (wait_cnt >= ack_delay) begin
                     logic [63:0] rd;
                     for (int i = 0; i < 8; i++) begin
                        int idx;
                        idx = (int'(mem_addr[11:0]) + i) % int'(MEM_BYTES);
                        rd[i*8 +: 8] = ram[idx];
                        if (mem_we) ram[idx] = mem_wdata[i*8 +: 8];
                     end
                     mem_rdata = rd;
                     mem_ack   = 1'b1;
                     wait_cnt  = 0;
                  end else begin
                     mem_rdata = {$urandom, $urandom};
                     mem_ack   = 1'b0;
                     wait_cnt++;
                  end
               end else begin
                  // Stray acks with no request outstanding must be ignored
                  wait_cnt  = 0;
                  mem_ack   = ($urandom_range(0, 3) == 0);
                  mem_rdata = {$urandom, $urandom};
               end
            end
         end
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
